// File: rtl/demux1ne4_if.sv
// Producer/consumer bundle for the demux1ne4 word distributor.
// Bcast exists only when DEMUX1NE4_BCAST_EN is defined.
interface demux1ne4_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] Hyrja;
    logic [1:0]       S;
    logic             Hyrja_valid;
    logic             Hyrja_ready;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [WIDTH-1:0] D3;
    logic [3:0]       V;
    logic [3:0]       R;
`ifdef DEMUX1NE4_BCAST_EN
    logic             Bcast;
`endif

    // master: producer plus the four consumers; slave: the distributor
    modport master (
        output Hyrja, S, Hyrja_valid, R,
`ifdef DEMUX1NE4_BCAST_EN
        output Bcast,
`endif
        input  Hyrja_ready, D0, D1, D2, D3, V
    );

    modport slave (
        input  Hyrja, S, Hyrja_valid, R,
`ifdef DEMUX1NE4_BCAST_EN
        input  Bcast,
`endif
        output Hyrja_ready, D0, D1, D2, D3, V
    );
endinterface

// File: rtl/demux1ne4.sv
// Registered 1-to-4 word distributor with one-entry slot per destination.
// Optional broadcast to all four slots when DEMUX1NE4_BCAST_EN is defined.
module demux1ne4 #(
    parameter int unsigned WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    demux1ne4_if.slave  bus
);
    logic [WIDTH-1:0] d_q [4];
    logic [WIDTH-1:0] d_d [4];
    logic [3:0]       v_q;
    logic [3:0]       v_d;
    logic [3:0]       free;
    logic [3:0]       target;
    logic             ready;
    logic             accept;

    always_comb begin
        // a slot being drained this cycle can be refilled in the same cycle
        free   = ~v_q | bus.R;
        target = 4'b0001 << bus.S;
        ready  = free[bus.S];
`ifdef DEMUX1NE4_BCAST_EN
        if (bus.Bcast) begin
            target = '1;
            ready  = &free;
        end
`endif
        accept = bus.Hyrja_valid & ready;
        for (int unsigned i = 0; i < 4; i++) begin
            d_d[i] = d_q[i];
            v_d[i] = v_q[i] & ~bus.R[i];
            if (accept && target[i]) begin
                d_d[i] = bus.Hyrja;
                v_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                d_q[i] <= '0;
            end
            v_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                d_q[i] <= d_d[i];
            end
            v_q <= v_d;
        end
    end

    assign bus.Hyrja_ready = ready;
    assign bus.D0          = d_q[0];
    assign bus.D1          = d_q[1];
    assign bus.D2          = d_q[2];
    assign bus.D3          = d_q[3];
    assign bus.V           = v_q;
endmodule

// File: tb/tb_demux1ne4.sv
// Directed vector bench for demux1ne4; broadcast sequence runs when
// DEMUX1NE4_BCAST_EN is defined.
module tb_demux1ne4;
    logic clk = 1'b0;
    logic rst;

    demux1ne4_if #(.WIDTH(16)) bus ();

    demux1ne4 #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        val;
        logic [1:0]  s;
        logic [15:0] h;
        logic [3:0]  r;
        logic        chk;
        logic        rdy;
        logic [3:0]  v;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] d3;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // producer must keep S/Hyrja stable while a word is pending
    logic        p_pend = 1'b0;
    logic [1:0]  p_s;
    logic [15:0] p_h;
    always @(posedge clk) begin
        if (!rst && p_pend && bus.Hyrja_valid)
            assert (bus.S == p_s && bus.Hyrja == p_h)
                else $error("protocol: S/Hyrja changed while word pending");
        p_pend <= !rst && bus.Hyrja_valid && !bus.Hyrja_ready;
        p_s    <= bus.S;
        p_h    <= bus.Hyrja;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic rs, input logic va, input logic [1:0] s, input logic [15:0] h,
                        input logic [3:0] r, input logic ck, input logic rd, input logic [3:0] v,
                        input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                        input logic [15:0] d3);
        vec_t t;
        t.rst = rs; t.val = va; t.s = s; t.h = h; t.r = r; t.chk = ck; t.rdy = rd;
        t.v = v; t.d0 = d0; t.d1 = d1; t.d2 = d2; t.d3 = d3;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic rs, input logic va, input logic [1:0] s,
                         input logic [15:0] h, input logic [3:0] r);
        rst             = rs;
        bus.Hyrja_valid = va;
        bus.S           = s;
        bus.Hyrja       = h;
        bus.R           = r;
    endtask

    task automatic step_chk(input string name, input logic [3:0] v, input logic [15:0] d0,
                            input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3);
        @(posedge clk);
        #1;
        check({name, ".V"},  {12'h000, bus.V}, {12'h000, v});
        check({name, ".D0"}, bus.D0, d0);
        check({name, ".D1"}, bus.D1, d1);
        check({name, ".D2"}, bus.D2, d2);
        check({name, ".D3"}, bus.D3, d3);
    endtask

    initial begin
`ifdef DEMUX1NE4_BCAST_EN
        bus.Bcast = 1'b0;
`endif
        // rst val S  Hyrja    R        chk rdy V        D0       D1       D2       D3
        push(1, 1, 0, 16'hFFFF, 4'b0000, 0, 0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push(1, 1, 0, 16'hFFFF, 4'b0000, 1, 1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push(0, 0, 0, 16'h0000, 4'b0000, 1, 1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push(0, 0, 1, 16'h0000, 4'b0000, 1, 1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push(0, 0, 2, 16'h0000, 4'b0000, 1, 1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push(0, 0, 3, 16'h0000, 4'b0000, 1, 1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // single route to D2, then stall until R[2]
        push(0, 1, 2, 16'hA5A5, 4'b0000, 1, 1, 4'b0100, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000);
        push(0, 1, 2, 16'h1111, 4'b0000, 1, 0, 4'b0100, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000);
        push(0, 1, 2, 16'h1111, 4'b0000, 1, 0, 4'b0100, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000);
        push(0, 1, 2, 16'h1111, 4'b0100, 1, 1, 4'b0100, 16'h0000, 16'h0000, 16'h1111, 16'h0000);
        push(0, 0, 2, 16'h0000, 4'b0100, 1, 1, 4'b0000, 16'h0000, 16'h0000, 16'h1111, 16'h0000);
        // back-to-back on D1
        push(0, 1, 1, 16'h0001, 4'b0010, 1, 1, 4'b0010, 16'h0000, 16'h0001, 16'h1111, 16'h0000);
        push(0, 1, 1, 16'h0002, 4'b0010, 1, 1, 4'b0010, 16'h0000, 16'h0002, 16'h1111, 16'h0000);
        push(0, 1, 1, 16'h0003, 4'b0010, 1, 1, 4'b0010, 16'h0000, 16'h0003, 16'h1111, 16'h0000);
        push(0, 0, 1, 16'h0000, 4'b0010, 1, 1, 4'b0000, 16'h0000, 16'h0003, 16'h1111, 16'h0000);
        // stall on D3 for four cycles, released by one-cycle R[3]
        push(0, 1, 3, 16'h0BAD, 4'b0000, 1, 1, 4'b1000, 16'h0000, 16'h0003, 16'h1111, 16'h0BAD);
        push(0, 1, 3, 16'h1234, 4'b0000, 1, 0, 4'b1000, 16'h0000, 16'h0003, 16'h1111, 16'h0BAD);
        push(0, 1, 3, 16'h1234, 4'b0000, 1, 0, 4'b1000, 16'h0000, 16'h0003, 16'h1111, 16'h0BAD);
        push(0, 1, 3, 16'h1234, 4'b0000, 1, 0, 4'b1000, 16'h0000, 16'h0003, 16'h1111, 16'h0BAD);
        push(0, 1, 3, 16'h1234, 4'b0000, 1, 0, 4'b1000, 16'h0000, 16'h0003, 16'h1111, 16'h0BAD);
        push(0, 1, 3, 16'h1234, 4'b1000, 1, 1, 4'b1000, 16'h0000, 16'h0003, 16'h1111, 16'h1234);
        push(0, 0, 3, 16'h0000, 4'b0000, 1, 0, 4'b1000, 16'h0000, 16'h0003, 16'h1111, 16'h1234);
        // accept on D0 while D3 drains
        push(0, 1, 0, 16'h0010, 4'b1000, 1, 1, 4'b0001, 16'h0010, 16'h0003, 16'h1111, 16'h1234);
        push(0, 1, 1, 16'h0011, 4'b0000, 1, 1, 4'b0011, 16'h0010, 16'h0011, 16'h1111, 16'h1234);
        push(0, 1, 2, 16'h0012, 4'b0000, 1, 1, 4'b0111, 16'h0010, 16'h0011, 16'h0012, 16'h1234);
        push(0, 1, 3, 16'h0013, 4'b0000, 1, 1, 4'b1111, 16'h0010, 16'h0011, 16'h0012, 16'h0013);
        push(0, 1, 0, 16'h7777, 4'b0000, 1, 0, 4'b1111, 16'h0010, 16'h0011, 16'h0012, 16'h0013);
        // parallel drain, then R with nothing held
        push(0, 0, 0, 16'h0000, 4'b1111, 1, 1, 4'b0000, 16'h0010, 16'h0011, 16'h0012, 16'h0013);
        push(0, 0, 0, 16'h0000, 4'b1111, 1, 1, 4'b0000, 16'h0010, 16'h0011, 16'h0012, 16'h0013);
        // reset mid-operation
        push(0, 1, 1, 16'hABCD, 4'b0000, 1, 1, 4'b0010, 16'h0010, 16'hABCD, 16'h0012, 16'h0013);
        push(1, 0, 1, 16'h0000, 4'b0000, 1, 0, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push(0, 0, 1, 16'h0000, 4'b0000, 1, 1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].val, tbl[i].s, tbl[i].h, tbl[i].r);
            #2;
            if (tbl[i].chk)
                check($sformatf("v%0d.ready", i), {15'h0, bus.Hyrja_ready}, {15'h0, tbl[i].rdy});
            step_chk($sformatf("v%0d", i), tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3);
        end

        // refill D0 while D0 and D2 both drain
        drive(0, 1, 0, 16'h00A0, 4'b0000);
        step_chk("fillA0", 4'b0001, 16'h00A0, 16'h0000, 16'h0000, 16'h0000);
        drive(0, 1, 2, 16'h00A2, 4'b0000);
        step_chk("fillA2", 4'b0101, 16'h00A0, 16'h0000, 16'h00A2, 16'h0000);
        drive(0, 1, 0, 16'h00B0, 4'b0101);
        #2;
        check("refill.ready", {15'h0, bus.Hyrja_ready}, 16'h0001);
        step_chk("refill", 4'b0001, 16'h00B0, 16'h0000, 16'h00A2, 16'h0000);
        drive(0, 0, 0, 16'h0000, 4'b0001);
        step_chk("drainB0", 4'b0000, 16'h00B0, 16'h0000, 16'h00A2, 16'h0000);

`ifdef DEMUX1NE4_BCAST_EN
        drive(0, 1, 1, 16'h2222, 4'b0000);
        step_chk("bc.pre", 4'b0010, 16'h00B0, 16'h2222, 16'h00A2, 16'h0000);
        bus.Bcast = 1'b1;
        drive(0, 1, 1, 16'hBEEF, 4'b0000);
        #2;
        check("bc.stall.ready", {15'h0, bus.Hyrja_ready}, 16'h0000);
        step_chk("bc.stall", 4'b0010, 16'h00B0, 16'h2222, 16'h00A2, 16'h0000);
        drive(0, 1, 1, 16'hBEEF, 4'b0010);
        #2;
        check("bc.go.ready", {15'h0, bus.Hyrja_ready}, 16'h0001);
        step_chk("bc.go", 4'b1111, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        bus.Bcast = 1'b0;
        drive(1, 0, 0, 16'h0000, 4'b0000);
        step_chk("bc.rst", 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        drive(0, 0, 0, 16'h0000, 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
